// File: rtl/game_pkg.sv
// Shared encodings and widths for the Pacman game sequencer.
package game_pkg;

   localparam int STATE_W = 3;
   localparam int LIVES_W = 2;
   localparam int LEVEL_W = 4;
   localparam int TIMER_W = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_PLAY  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DYING = 3'd4,
      ST_CLEAR = 3'd5,
      ST_OVER  = 3'd6
   } game_state_t;

endpackage

// File: rtl/game_flow_ctrl_frame_timer.sv
// Frame counter for timed phases: clears on phase change, counts frame ticks,
// and flags the tick that completes a phase lasting `limit` frames.
import game_pkg::*;

module frame_timer (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               tick,
   input  logic [TIMER_W-1:0] limit,
   output logic [TIMER_W-1:0] count,
   output logic               expire
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (tick)
         count <= count + 1'b1;
   end

   assign expire = tick && (count == limit - 1'b1);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game phase sequencer: drives movement enable, respawn/refill strobes,
// lives/level counters and the game-over flag.
//
// state | meaning
// IDLE  | waiting for start after reset
// READY | get-ready pause before play
// PLAY  | actors moving
// PAUSE | user pause, hits and clears ignored
// DYING | death animation after ghost crash
// CLEAR | level-clear animation
// OVER  | game over, waiting for restart
import game_pkg::*;

module game_flow_ctrl #(
   parameter int LIVES        = 3,
   parameter int READY_FRAMES = 60,
   parameter int DEATH_FRAMES = 120,
   parameter int CLEAR_FRAMES = 90,
   parameter int MAX_LEVEL    = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start_req,
   input  logic               pause_req,
   input  logic               ghost_hit,
   input  logic               beans_empty,
   output logic [STATE_W-1:0] state,
   output logic               run_en,
   output logic               actor_rst,
   output logic               bean_rst,
   output logic [LIVES_W-1:0] lives,
   output logic [LEVEL_W-1:0] level,
   output logic               over
);

   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);

   game_state_t        state_nx;
   logic [LIVES_W-1:0] lives_nx;
   logic [LEVEL_W-1:0] level_nx;
   logic               actor_nx;
   logic               bean_nx;
   logic [TIMER_W-1:0] limit;
   logic [TIMER_W-1:0] timer_count;
   logic               expire;

   always_comb begin
      limit = '0;
      case (state)
         ST_READY: limit = TIMER_W'(READY_FRAMES);
         ST_DYING: limit = TIMER_W'(DEATH_FRAMES);
         ST_CLEAR: limit = TIMER_W'(CLEAR_FRAMES);
         default:  limit = '0;
      endcase
   end

   frame_timer u_frame_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (state_nx != state),
      .tick   (frame_tick),
      .limit  (limit),
      .count  (timer_count),
      .expire (expire)
   );

   always_comb begin
      state_nx = game_state_t'(state);
      lives_nx = lives;
      level_nx = level;
      actor_nx = 1'b0;
      bean_nx  = 1'b0;
      case (state)
         ST_IDLE, ST_OVER: begin
            if (start_req) begin
               state_nx = ST_READY;
               lives_nx = LIVES_INIT;
               level_nx = LEVEL_W'(1);
               actor_nx = 1'b1;
               bean_nx  = 1'b1;
            end
         end
         ST_READY: begin
            if (expire) state_nx = ST_PLAY;
         end
         ST_PLAY: begin
            // last dot eaten wins over a simultaneous crash
            if (beans_empty) begin
               state_nx = ST_CLEAR;
            end else if (ghost_hit) begin
               state_nx = ST_DYING;
               lives_nx = lives - 1'b1;
            end else if (pause_req) begin
               state_nx = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (pause_req) state_nx = ST_PLAY;
         end
         ST_DYING: begin
            if (expire) begin
               if (lives == '0) begin
                  state_nx = ST_OVER;
               end else begin
                  state_nx = ST_READY;
                  actor_nx = 1'b1;
               end
            end
         end
         ST_CLEAR: begin
            if (expire) begin
               state_nx = ST_READY;
               level_nx = (level < LEVEL_MAX) ? level + 1'b1 : LEVEL_MAX;
               actor_nx = 1'b1;
               bean_nx  = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         run_en    <= 1'b0;
         actor_rst <= 1'b0;
         bean_rst  <= 1'b0;
         lives     <= LIVES_INIT;
         level     <= LEVEL_W'(1);
         over      <= 1'b0;
      end else begin
         state     <= state_nx;
         run_en    <= (state_nx == ST_PLAY);
         actor_rst <= actor_nx;
         bean_rst  <= bean_nx;
         lives     <= lives_nx;
         level     <= level_nx;
         over      <= (state_nx == ST_OVER);
      end
   end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: full game flow, death, clear saturation,
// pause and asynchronous reset.
module tb_game_flow_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start_req = 1'b0;
   logic       pause_req = 1'b0;
   logic       ghost_hit = 1'b0;
   logic       beans_empty = 1'b0;
   logic [2:0] state;
   logic       run_en, actor_rst, bean_rst, over;
   logic [1:0] lives;
   logic [3:0] level;

   int checks = 0;
   int failures = 0;

   game_flow_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .frame_tick  (frame_tick),
      .start_req   (start_req),
      .pause_req   (pause_req),
      .ghost_hit   (ghost_hit),
      .beans_empty (beans_empty),
      .state       (state),
      .run_en      (run_en),
      .actor_rst   (actor_rst),
      .bean_rst    (bean_rst),
      .lives       (lives),
      .level       (level),
      .over        (over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
      end
   endtask

   // single tick, leaves sampling point on the first cycle after it
   task automatic one_tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic to_play();
      do_ticks(59);
      chk("ready_hold", state, 1);
      one_tick();
      chk("play_state", state, 2);
      chk("play_run_en", run_en, 1);
      step();
   endtask

   // crash from PLAY, then run the death animation out
   task automatic hit_and_die(input int exp_lives, input int exp_dest);
      ghost_hit = 1'b1;
      step();
      ghost_hit = 1'b0;
      chk("dying_state", state, 4);
      chk("dying_lives", lives, exp_lives);
      chk("dying_run_en", run_en, 0);
      do_ticks(119);
      chk("dying_hold", state, 4);
      one_tick();
      chk("death_dest", state, exp_dest);
      chk("death_actor_rst", actor_rst, (exp_dest == 1) ? 1 : 0);
      chk("death_bean_rst", bean_rst, 0);
      chk("death_over", over, (exp_dest == 6) ? 1 : 0);
      step();
      chk("death_actor_rst_end", actor_rst, 0);
   endtask

   task automatic clear_level(input int exp_level);
      beans_empty = 1'b1;
      step();
      beans_empty = 1'b0;
      chk("clear_state", state, 5);
      do_ticks(89);
      chk("clear_hold", state, 5);
      one_tick();
      chk("clear_dest", state, 1);
      chk("clear_level", level, exp_level);
      chk("clear_bean_rst", bean_rst, 1);
      chk("clear_actor_rst", actor_rst, 1);
      step();
      chk("clear_strobe_end", bean_rst | actor_rst, 0);
   endtask

   initial begin
      step();
      step();
      chk("rst_state", state, 0);
      chk("rst_lives", lives, 3);
      chk("rst_level", level, 1);
      chk("rst_outs", {run_en, actor_rst, bean_rst, over}, 0);
      rst = 1'b0;
      repeat (8) step();

      start_req = 1'b1;
      step();
      start_req = 1'b0;
      chk("start_state", state, 1);
      chk("start_bean_rst", bean_rst, 1);
      chk("start_actor_rst", actor_rst, 1);
      chk("start_lives", lives, 3);
      chk("start_level", level, 1);
      step();
      chk("start_strobe_end", bean_rst | actor_rst, 0);
      to_play();

      hit_and_die(2, 1);
      to_play();
      hit_and_die(1, 1);
      to_play();
      hit_and_die(0, 6);
      chk("over_run_en", run_en, 0);
      do_ticks(3);
      chk("over_hold", state, 6);

      start_req = 1'b1;
      step();
      start_req = 1'b0;
      chk("restart_state", state, 1);
      chk("restart_lives", lives, 3);
      chk("restart_level", level, 1);
      chk("restart_over", over, 0);
      chk("restart_strobes", {bean_rst, actor_rst}, 3);
      step();
      to_play();

      ghost_hit = 1'b1;
      beans_empty = 1'b1;
      step();
      ghost_hit = 1'b0;
      beans_empty = 1'b0;
      chk("both_state", state, 5);
      chk("both_lives", lives, 3);
      do_ticks(89);
      one_tick();
      chk("first_clear_level", level, 2);
      chk("first_clear_strobes", {bean_rst, actor_rst}, 3);
      step();
      for (int lv = 3; lv <= 15; lv++) begin
         to_play();
         clear_level(lv);
      end
      to_play();
      clear_level(15);
      chk("sat_lives", lives, 3);

      to_play();
      start_req = 1'b1;
      step();
      start_req = 1'b0;
      chk("start_in_play", state, 2);
      pause_req = 1'b1;
      step();
      pause_req = 1'b0;
      chk("pause_state", state, 3);
      chk("pause_run_en", run_en, 0);
      ghost_hit = 1'b1;
      step();
      ghost_hit = 1'b0;
      beans_empty = 1'b1;
      step();
      beans_empty = 1'b0;
      chk("pause_ignore_state", state, 3);
      chk("pause_lives", lives, 3);
      pause_req = 1'b1;
      step();
      pause_req = 1'b0;
      chk("resume_state", state, 2);
      chk("resume_run_en", run_en, 1);

      ghost_hit = 1'b1;
      step();
      ghost_hit = 1'b0;
      chk("pre_rst_dying", state, 4);
      chk("pre_rst_lives", lives, 2);
      do_ticks(50);
      #2;
      rst = 1'b1;
      #1;
      chk("async_state", state, 0);
      chk("async_lives", lives, 3);
      chk("async_level", level, 1);
      chk("async_outs", {run_en, actor_rst, bean_rst, over}, 0);
      step();
      rst = 1'b0;
      do_ticks(5);
      chk("post_rst_idle", state, 0);
      chk("post_rst_run_en", run_en, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
